ram_access: RTL and testbench
=============================

# ram_access

Downstream consumer of the RAM/bus enable decode. Takes the CPU-side `cs_ram` strobe, `rwbar` and `address`, and turns each 6502 bus cycle into a single read or write on the FPGA block RAM in the `fpga_clk` domain. On reads it drives the CPU data bus while `phi2` is high; on writes it captures CPU data a fixed number of cycles into `phi2` high. `phi2` is asynchronous to `fpga_clk`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: RAM address width; low `ADDR_WIDTH` bits of `address`.
- `RD_LATENCY`, default 2: cycles from `ram_re` to valid `ram_rdata`; legal range 1..3.
- `WR_SAMPLE`, default 4: `fpga_clk` cycles after the detected `phi2` rise at which `data_in` is captured; legal range 2..7.

Ports:
- `fpga_clk` in 1: system clock. One clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `phi2` in 1: CPU phase-2 clock, asynchronous.
- `address` in 16: CPU address, stable before `phi2` rises.
- `rwbar` in 1: CPU read (1) or write (0).
- `cs_ram` in 1: RAM select from the enable decode, already gated by `phi2`.
- `data_in` in 8: CPU data bus input.
- `ram_rdata` in 8: RAM read data.
- `ram_addr` out ADDR_WIDTH: RAM address.
- `ram_re` out 1: one-cycle read strobe.
- `ram_we` out 1: one-cycle write strobe.
- `ram_wdata` out 8: RAM write data.
- `data_out` out 8: data driven to the CPU bus.
- `data_oe` out 1: CPU bus output enable.
- `late_error` out 1: sticky flag; a read was not complete when `phi2` fell.

## Operation
- `phi2` passes through a 2-flop synchronizer (`phi2_s`) and one delay flop (`phi2_d`). `rise = phi2_s & !phi2_d`, `fall = !phi2_s & phi2_d`.
- On `rise`, register `address[ADDR_WIDTH-1:0]` into `ram_addr`, and register `rwbar` and `cs_ram`. These are raw inputs; they are stable by then.
- States:
  - IDLE: on `rise` with `cs_ram=1`, go to READ when `rwbar=1`, otherwise WRITE. With `cs_ram=0`, stay in IDLE.
  - READ: pulse `ram_re` in the first cycle. Count `RD_LATENCY` cycles, then load `ram_rdata` into `data_out` and go to HOLD.
  - HOLD: `data_oe = 1 & phi2` (raw `phi2` gate so the bus is released promptly).
  - WRITE: count from `rise`. In cycle `WR_SAMPLE`, load `data_in` into `ram_wdata`, pulse `ram_we`, and go to WAIT_LOW.
  - WAIT_LOW: idle until `fall`.
- `fall` returns any state to IDLE, with priority over all other transitions.
  - `fall` in READ: no `data_out` update; set `late_error`.
  - `fall` in WRITE before the sample cycle: no `ram_we`.
- A `rise` outside IDLE is ignored. It cannot occur legally, because `fall` always precedes it.
- `late_error` is cleared only by reset.
- Counter is 3 bits and saturates; it never wraps.

## Timing
- Reset values: all outputs 0, state IDLE, synchronizer flops 0.
- `reset_n` asserted mid-cycle aborts immediately: `ram_we`/`ram_re` drop, `data_oe` = 0.
- Detection latency: `phi2` rise to `rise` is 2–3 `fpga_clk` cycles.
- Read: `ram_re` one cycle after `rise`. `data_out` valid and `data_oe` high `RD_LATENCY+1` cycles after `ram_re`.
- Write: `ram_we` high exactly `WR_SAMPLE` cycles after `rise`, for 1 cycle.
- Exactly one `ram_re` or `ram_we` per selected `phi2` high period; none when `cs_ram=0`.
- Minimum `phi2` high time supported: `max(RD_LATENCY+2, WR_SAMPLE+1) + 3` cycles.

## Structure
- Shared package holds the state encoding enum (IDLE, READ, HOLD, WRITE, WAIT_LOW) and the counter width constant.
- One natural sub-module: `sync_edge`, a 2-flop synchronizer plus rise/fall detector, reusable for other async CPU strobes.

## Test plan
- Reset: hold `reset_n`=0 while toggling `phi2` → all outputs stay 0. Release → IDLE, no strobes until the next `rise`.
- Read: `address`=0x1234, `rwbar`=1, `cs_ram`=1, `ram_rdata`=0xA5 with latency 2, `phi2` high 12 cycles → one `ram_re`, `ram_addr`=0x1234, `data_out`=0xA5, `data_oe` high until `phi2` falls, then 0.
- Write: `address`=0x0800, `rwbar`=0, `data_in`=0x3C, `phi2` high 12 cycles → one `ram_we` exactly 4 cycles after `rise`, `ram_wdata`=0x3C, `data_oe` never high.
- Unselected: `cs_ram`=0 for 3 consecutive `phi2` cycles → no `ram_re`/`ram_we`, `data_oe`=0 throughout.
- Short `phi2`: high for 3 cycles on a read → no `data_oe`, `late_error`=1 and stays 1 through a following good read.
- Mid-op reset: assert `reset_n`=0 during HOLD → `data_oe` and `data_out` 0 immediately. After release, the next read completes normally.

Source files
------------

// File: rtl/ram_access_pkg.sv
// ram_access_pkg
// Shared definitions for the CPU-to-block-RAM access bridge:
//   - state_e : bus-cycle sequencer states
//   - CNT_W   : width of the in-cycle counter
//   - sat_inc : saturating increment for that counter
package ram_access_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_HOLD,
    ST_WRITE,
    ST_WAIT_LOW
  } state_e;

  // The counter sticks at all-ones so a long phi2 high phase can never
  // wrap it back into a value that re-triggers a strobe.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ram_access_sync_edge.sv
// sync_edge
// Two-flop synchronizer for an asynchronous strobe, followed by one delay
// flop so single-cycle rise/fall pulses can be generated in the clock domain.
// Ports:
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset
//   i_async  : asynchronous input level
//   o_rise   : one-cycle pulse, synchronized input went 0->1
//   o_fall   : one-cycle pulse, synchronized input went 1->0
module sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_dly;
  assign o_fall = ~r_sync & r_dly;

endmodule

// File: rtl/ram_access.sv
// ram_access
// Turns each selected 6502 bus cycle (one phi2 high phase) into exactly one
// block-RAM read or write in the fpga_clk domain.
// Ports:
//   fpga_clk, reset_n       : clock, asynchronous active-low reset
//   phi2                    : CPU phase-2 clock (asynchronous)
//   address, rwbar, cs_ram  : CPU cycle description, stable before phi2 rises
//   data_in                 : CPU write data
//   ram_rdata               : RAM read data, RD_LATENCY cycles after ram_re
//   ram_addr/ram_re/ram_we/ram_wdata : RAM port
//   data_out/data_oe        : CPU read data and bus enable
//   late_error              : sticky, a read was cut short by phi2 falling
module ram_access
  import ram_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 2,
  parameter int WR_SAMPLE  = 4
) (
  input  logic                  fpga_clk,
  input  logic                  reset_n,
  input  logic                  phi2,
  input  logic [15:0]           address,
  input  logic                  rwbar,
  input  logic                  cs_ram,
  input  logic [7:0]            data_in,
  input  logic [7:0]            ram_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic [7:0]            ram_wdata,
  output logic [7:0]            data_out,
  output logic                  data_oe,
  output logic                  late_error
);

  // Read data is taken RD_LATENCY cycles after the cycle that strobed ram_re.
  localparam logic [CNT_W-1:0] RD_DONE = CNT_W'(RD_LATENCY);
  // Write counting starts at 1 in the cycle after rise; the strobe is
  // registered, so it is scheduled one count early to land on WR_SAMPLE.
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_SAMPLE - 1);

  logic w_rise;
  logic w_fall;

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic             r_rwbar;
  logic             r_cs;
  logic [7:0]       r_data_out;
  logic [7:0]       r_ram_wdata;
  logic             r_ram_we;
  logic             r_late_error;

  logic w_start;
  logic w_re;
  logic w_load_dout;
  logic w_load_wdata;
  logic w_set_late;

  sync_edge u_phi2_sync (
    .i_clk   (fpga_clk),
    .i_rst_n (reset_n),
    .i_async (phi2),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_start      = 1'b0;
    w_re         = 1'b0;
    w_load_dout  = 1'b0;
    w_load_wdata = 1'b0;
    w_set_late   = 1'b0;

    // A falling phi2 ends the bus cycle whatever stage it reached.
    if (w_fall) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
      w_set_late   = (r_state == ST_READ);
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_start = 1'b1;
            if (cs_ram) begin
              w_state_next = rwbar ? ST_READ : ST_WRITE;
              w_cnt_next   = rwbar ? '0 : CNT_W'(1);
            end
          end
        end
        ST_READ: begin
          w_re       = (r_cnt == '0) && r_cs && r_rwbar;
          w_cnt_next = sat_inc(r_cnt);
          if (r_cnt == RD_DONE) begin
            w_load_dout  = 1'b1;
            w_state_next = ST_HOLD;
          end
        end
        ST_WRITE: begin
          w_cnt_next = sat_inc(r_cnt);
          if (r_cnt == WR_LAST) begin
            w_load_wdata = 1'b1;
            w_state_next = ST_WAIT_LOW;
          end
        end
        ST_HOLD, ST_WAIT_LOW: begin
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_ram_addr   <= '0;
      r_rwbar      <= 1'b0;
      r_cs         <= 1'b0;
      r_data_out   <= '0;
      r_ram_wdata  <= '0;
      r_ram_we     <= 1'b0;
      r_late_error <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_ram_we <= w_load_wdata;
      if (w_start) begin
        r_ram_addr <= address[ADDR_WIDTH-1:0];
        r_rwbar    <= rwbar;
        r_cs       <= cs_ram;
      end
      if (w_load_dout) begin
        r_data_out <= ram_rdata;
      end
      if (w_load_wdata) begin
        r_ram_wdata <= data_in;
      end
      if (w_set_late) begin
        r_late_error <= 1'b1;
      end
    end
  end

  assign ram_addr   = r_ram_addr;
  assign ram_re     = w_re;
  assign ram_we     = r_ram_we;
  assign ram_wdata  = r_ram_wdata;
  assign data_out   = r_data_out;
  // Raw phi2 gate: the bus is released as soon as the CPU drops phi2,
  // without waiting for the synchronized fall.
  assign data_oe    = (r_state == ST_HOLD) & phi2;
  assign late_error = r_late_error;

endmodule

// File: tb/tb_ram_access.sv
// tb_ram_access
// Directed bench for ram_access with default parameters. A two-stage RAM
// model answers ram_re; a negedge monitor counts strobes and bus drives.
module tb_ram_access;

  logic        fpga_clk = 1'b0;
  logic        reset_n  = 1'b0;
  logic        phi2     = 1'b0;
  logic [15:0] address  = 16'h0000;
  logic        rwbar    = 1'b1;
  logic        cs_ram   = 1'b0;
  logic [7:0]  data_in  = 8'h00;
  logic [7:0]  ram_rdata;
  logic [15:0] ram_addr;
  logic        ram_re;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        late_error;

  ram_access dut (
    .fpga_clk   (fpga_clk),
    .reset_n    (reset_n),
    .phi2       (phi2),
    .address    (address),
    .rwbar      (rwbar),
    .cs_ram     (cs_ram),
    .data_in    (data_in),
    .ram_rdata  (ram_rdata),
    .ram_addr   (ram_addr),
    .ram_re     (ram_re),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .late_error (late_error)
  );

  always #5 fpga_clk = ~fpga_clk;

  int cyc = 0;
  always @(posedge fpga_clk) cyc <= cyc + 1;

  // RAM model with read latency 2; returns 0 unless a read was strobed.
  logic [7:0] rd_value = 8'h00;
  logic [7:0] p1 = 8'h00;
  logic [7:0] p2 = 8'h00;
  always @(posedge fpga_clk) begin
    p1 <= ram_re ? rd_value : 8'h00;
    p2 <= p1;
  end
  assign ram_rdata = p2;

  // Monitor (sole writer of these counters).
  int   re_cnt = 0, we_cnt = 0, oe_cnt = 0, bad_oe = 0, nz_cnt = 0;
  int   re_cyc = -1, we_cyc = -1, oe_rise_cyc = -1;
  logic [7:0] we_data = 8'h00;
  logic oe_prev = 1'b0;
  always @(negedge fpga_clk) begin
    if (ram_re) begin
      re_cnt <= re_cnt + 1;
      re_cyc <= cyc;
    end
    if (ram_we) begin
      we_cnt  <= we_cnt + 1;
      we_cyc  <= cyc;
      we_data <= ram_wdata;
    end
    if (data_oe) begin
      oe_cnt <= oe_cnt + 1;
      if (!oe_prev) oe_rise_cyc <= cyc;
      if (!phi2 || data_out !== rd_value) bad_oe <= bad_oe + 1;
    end
    oe_prev <= data_oe;
    if (!reset_n && ({ram_addr, ram_re, ram_we, ram_wdata, data_out, data_oe, late_error} != '0))
      nz_cnt <= nz_cnt + 1;
  end

  int passed = 0;
  int total  = 0;
  int rise_cyc = 0;
  int b_re, b_we, b_oe, b_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge fpga_clk);
      #1;
    end
  endtask

  task automatic snap();
    b_re  = re_cnt;
    b_we  = we_cnt;
    b_oe  = oe_cnt;
    b_bad = bad_oe;
  endtask

  // One phi2 period; cs_ram is gated by phi2 as the decoder would do.
  task automatic run_phase(input logic [15:0] a, input logic rw, input logic cs,
                           input logic [7:0] din, input int high, input int low);
    address  = a;
    rwbar    = rw;
    data_in  = din;
    phi2     = 1'b1;
    cs_ram   = cs;
    rise_cyc = cyc;
    tick(high);
    phi2   = 1'b0;
    cs_ram = 1'b0;
    tick(low);
  endtask

  initial begin
    tick(2);
    // Reset held while phi2 toggles with a selected read.
    snap();
    for (int i = 0; i < 3; i++) run_phase(16'h1111, 1'b1, 1'b1, 8'h00, 6, 4);
    chk("reset_outputs_zero", 32'(nz_cnt), 32'd0);
    chk("reset_no_re", 32'(re_cnt - b_re), 32'd0);
    reset_n = 1'b1;
    snap();
    tick(8);
    chk("idle_no_strobes", 32'((re_cnt - b_re) + (we_cnt - b_we)), 32'd0);
    chk("idle_ram_addr", 32'(ram_addr), 32'd0);
    chk("idle_late_error", 32'(late_error), 32'd0);
    $display("reset: nz=%0d late_error=%0d", nz_cnt, late_error);

    // Read 0x1234 -> 0xA5.
    rd_value = 8'hA5;
    snap();
    run_phase(16'h1234, 1'b1, 1'b1, 8'h00, 12, 6);
    chk("rd_re_count", 32'(re_cnt - b_re), 32'd1);
    chk("rd_re_cycle", 32'(re_cyc), 32'(rise_cyc + 3));
    chk("rd_addr", 32'(ram_addr), 32'h1234);
    chk("rd_oe_start", 32'(oe_rise_cyc), 32'(rise_cyc + 6));
    chk("rd_oe_cycles", 32'(oe_cnt - b_oe), 32'd6);
    chk("rd_oe_data", 32'(bad_oe - b_bad), 32'd0);
    chk("rd_oe_released", 32'(data_oe), 32'd0);
    chk("rd_data_out", 32'(data_out), 32'hA5);
    chk("rd_no_we", 32'(we_cnt - b_we), 32'd0);
    $display("read 1234: re=%0d oe=%0d data_out=%0h", re_cnt - b_re, oe_cnt - b_oe, data_out);

    // Write 0x3C to 0x0800.
    snap();
    run_phase(16'h0800, 1'b0, 1'b1, 8'h3C, 12, 6);
    chk("wr_we_count", 32'(we_cnt - b_we), 32'd1);
    chk("wr_we_cycle", 32'(we_cyc), 32'(rise_cyc + 6));
    chk("wr_strobe_data", 32'(we_data), 32'h3C);
    chk("wr_addr", 32'(ram_addr), 32'h0800);
    chk("wr_no_oe", 32'(oe_cnt - b_oe), 32'd0);
    chk("wr_no_re", 32'(re_cnt - b_re), 32'd0);
    $display("write 0800: we=%0d wdata=%0h", we_cnt - b_we, we_data);

    // Three unselected cycles.
    snap();
    for (int i = 0; i < 3; i++) run_phase(16'h4000, 1'b1, 1'b0, 8'h00, 12, 6);
    chk("unsel_no_strobes", 32'((re_cnt - b_re) + (we_cnt - b_we)), 32'd0);
    chk("unsel_no_oe", 32'(oe_cnt - b_oe), 32'd0);
    $display("unselected x3: re=%0d we=%0d oe=%0d", re_cnt - b_re, we_cnt - b_we, oe_cnt - b_oe);

    // Short phi2 on a read.
    rd_value = 8'h5A;
    snap();
    run_phase(16'h2000, 1'b1, 1'b1, 8'h00, 3, 6);
    chk("short_re_count", 32'(re_cnt - b_re), 32'd1);
    chk("short_no_oe", 32'(oe_cnt - b_oe), 32'd0);
    chk("short_late_error", 32'(late_error), 32'd1);
    chk("short_data_kept", 32'(data_out), 32'hA5);
    $display("short read: late_error=%0d data_out=%0h", late_error, data_out);

    // Good read after the error: flag stays set.
    rd_value = 8'hC3;
    snap();
    run_phase(16'h1235, 1'b1, 1'b1, 8'h00, 12, 6);
    chk("after_late_sticky", 32'(late_error), 32'd1);
    chk("after_oe_cycles", 32'(oe_cnt - b_oe), 32'd6);
    chk("after_data_out", 32'(data_out), 32'hC3);
    chk("after_oe_data", 32'(bad_oe - b_bad), 32'd0);
    $display("read 1235: data_out=%0h late_error=%0d", data_out, late_error);

    // Reset during HOLD.
    rd_value = 8'h77;
    address  = 16'h3000;
    rwbar    = 1'b1;
    phi2     = 1'b1;
    cs_ram   = 1'b1;
    tick(8);
    chk("hold_oe_before_reset", 32'(data_oe), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_oe", 32'(data_oe), 32'd0);
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_late_clear", 32'(late_error), 32'd0);
    phi2   = 1'b0;
    cs_ram = 1'b0;
    tick(4);
    reset_n = 1'b1;
    tick(4);
    rd_value = 8'h99;
    snap();
    run_phase(16'h0042, 1'b1, 1'b1, 8'h00, 12, 6);
    chk("post_rst_re_count", 32'(re_cnt - b_re), 32'd1);
    chk("post_rst_addr", 32'(ram_addr), 32'h0042);
    chk("post_rst_oe_cycles", 32'(oe_cnt - b_oe), 32'd6);
    chk("post_rst_data_out", 32'(data_out), 32'h99);
    chk("reset_outputs_zero_all", 32'(nz_cnt), 32'd0);
    $display("post-reset read 0042: data_out=%0h", data_out);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
